axi_wr_frontend: RTL and testbench

Per-client AXI write front-end that sits directly upstream of the AXI-to-OCP converter's arbiter. It accepts one AXI write burst at a time: an address phase followed by 1–16 data beats. It assembles the burst into a single address+data packet, raises a valid to the arbiter and holds the packet stable until consumed. It then returns the AXI write response. Two instances (client 1, client 2) feed the converter's write-packet inputs.

---
 rtl/axi_wr_frontend_if.sv | 35 +++
 rtl/axi_wr_frontend.sv | 102 ++++++++++
 tb/tb_axi_wr_frontend.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_frontend_if.sv
// AXI write-channel bundle plus the packet handoff towards the converter arbiter.
// slave is the front-end's view; master is the client/converter side.
interface axi_wr_frontend_if;
    logic         awvalid;
    logic         awready;
    logic [3:0]   awid;
    logic [3:0]   awlen;
    logic [31:0]  awaddr;
    logic         wvalid;
    logic         wready;
    logic [3:0]   wid;
    logic [31:0]  wdata;
    logic         wlast;
    logic         bvalid;
    logic         bready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         pkt_vld;
    logic [551:0] pkt;
    logic         pkt_taken;

    modport slave (
        input  awvalid, awid, awlen, awaddr,
        input  wvalid, wid, wdata, wlast,
        input  bready, pkt_taken,
        output awready, wready, bvalid, bid, bresp, pkt_vld, pkt
    );

    modport master (
        output awvalid, awid, awlen, awaddr,
        output wvalid, wid, wdata, wlast,
        output bready, pkt_taken,
        input  awready, wready, bvalid, bid, bresp, pkt_vld, pkt
    );
endinterface

// File: rtl/axi_wr_frontend.sv
// Per-client AXI write front-end: gathers one burst (1-16 beats) into a packet,
// holds it for the arbiter until consumed, then returns the write response.
module axi_wr_frontend #(
    parameter bit CHECK_WID = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    axi_wr_frontend_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DATA, PEND, RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_id;
    logic [3:0]         r_len;
    logic [31:0]        r_addr;
    logic [15:0][31:0]  r_data;
    logic [3:0]         r_cnt;
    logic               r_err;

    logic               w_final;
    logic               w_beat_err;
    logic               w_awready;
    logic               w_wready;
    logic               w_bvalid;
    logic               w_pkt_vld;
    logic [3:0]         w_bid;
    logic [1:0]         w_bresp;

    always_comb begin
        w_next     = r_state;
        w_final    = bus.wlast || (r_cnt == r_len);
        w_beat_err = (bus.wlast != (r_cnt == r_len)) || (CHECK_WID && (bus.wid != r_id));
        case (r_state)
            IDLE:    if (bus.awvalid)             w_next = DATA;
            DATA:    if (bus.wvalid && w_final)   w_next = PEND;
            PEND:    if (bus.pkt_taken)           w_next = RESP;
            RESP:    if (bus.bready)              w_next = IDLE;
            default:                              w_next = IDLE;
        endcase

        // rst gates the outputs so they read 0 during the whole reset window,
        // not only after the first reset edge.
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_pkt_vld = 1'b0;
        w_bvalid  = 1'b0;
        w_bid     = '0;
        w_bresp   = '0;
        if (!rst) begin
            w_awready = (r_state == IDLE);
            w_wready  = (r_state == DATA);
            w_pkt_vld = (r_state == PEND);
            w_bvalid  = (r_state == RESP);
            if (r_state == RESP) begin
                w_bid   = r_id;
                w_bresp = r_err ? 2'b10 : 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.awvalid) begin
                r_id   <= bus.awid;
                r_len  <= bus.awlen;
                r_addr <= bus.awaddr;
                r_data <= '0;
                r_cnt  <= '0;
                r_err  <= 1'b0;
            end
            if (r_state == DATA && bus.wvalid) begin
                r_data[r_cnt] <= bus.wdata;
                if (!w_final) begin
                    r_cnt <= r_cnt + 4'd1;
                end
                if (w_beat_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.awready = w_awready;
    assign bus.wready  = w_wready;
    assign bus.bvalid  = w_bvalid;
    assign bus.bid     = w_bid;
    assign bus.bresp   = w_bresp;
    assign bus.pkt_vld = w_pkt_vld;
    assign bus.pkt     = rst ? '0 : {r_id, r_len, r_addr, r_data};

endmodule

// File: tb/tb_axi_wr_frontend.sv
// Bench for axi_wr_frontend: two instances (wid checking on/off) share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_axi_wr_frontend;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_wr_frontend_if bus1();
    axi_wr_frontend_if bus0();

    assign bus0.awvalid   = bus1.awvalid;
    assign bus0.awid      = bus1.awid;
    assign bus0.awlen     = bus1.awlen;
    assign bus0.awaddr    = bus1.awaddr;
    assign bus0.wvalid    = bus1.wvalid;
    assign bus0.wid       = bus1.wid;
    assign bus0.wdata     = bus1.wdata;
    assign bus0.wlast     = bus1.wlast;
    assign bus0.bready    = bus1.bready;
    assign bus0.pkt_taken = bus1.pkt_taken;

    axi_wr_frontend #(.CHECK_WID(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    axi_wr_frontend #(.CHECK_WID(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkp(input string name, input logic [551:0] act, input logic [551:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=handshake t=%0t", name, $time);
    endtask

    // Transaction-level reference: a burst is a list of words plus two error flags.
    typedef enum {M_IDLE, M_DATA, M_PEND, M_RESP} mph_t;
    mph_t              ph        = M_IDLE;
    logic [3:0]        m_id      = '0;
    logic [3:0]        m_len     = '0;
    logic [31:0]       m_addr    = '0;
    logic [15:0][31:0] m_words   = '0;
    int                m_beats   = 0;
    bit                m_err_len = 1'b0;
    bit                m_err_wid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ph = M_IDLE; m_id = '0; m_len = '0; m_addr = '0; m_words = '0;
            m_beats = 0; m_err_len = 1'b0; m_err_wid = 1'b0;
        end else begin
            case (ph)
                M_IDLE: if (bus1.awvalid) begin
                    m_id = bus1.awid; m_len = bus1.awlen; m_addr = bus1.awaddr;
                    m_words = '0; m_beats = 0; m_err_len = 1'b0; m_err_wid = 1'b0;
                    ph = M_DATA;
                end
                M_DATA: if (bus1.wvalid) begin
                    m_words[4'(m_beats)] = bus1.wdata;
                    if (bus1.wid != m_id) m_err_wid = 1'b1;
                    if (bus1.wlast || m_beats == int'(m_len)) begin
                        m_err_len = (bus1.wlast != (m_beats == int'(m_len)));
                        ph = M_PEND;
                    end
                    m_beats++;
                end
                M_PEND: if (bus1.pkt_taken) ph = M_RESP;
                M_RESP: if (bus1.bready) ph = M_IDLE;
                default: ph = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [551:0] e_pkt;
            logic         e_resp;
            e_pkt  = rst ? '0 : {m_id, m_len, m_addr, m_words};
            e_resp = !rst && ph == M_RESP;
            chk1("awready1", bus1.awready, !rst && ph == M_IDLE);
            chk1("awready0", bus0.awready, !rst && ph == M_IDLE);
            chk1("wready1",  bus1.wready,  !rst && ph == M_DATA);
            chk1("wready0",  bus0.wready,  !rst && ph == M_DATA);
            chk1("pkt_vld1", bus1.pkt_vld, !rst && ph == M_PEND);
            chk1("pkt_vld0", bus0.pkt_vld, !rst && ph == M_PEND);
            chk1("bvalid1",  bus1.bvalid,  e_resp);
            chk1("bvalid0",  bus0.bvalid,  e_resp);
            chkp("pkt1", bus1.pkt, e_pkt);
            chkp("pkt0", bus0.pkt, e_pkt);
            if (e_resp) begin
                chk32("bid1",   32'(bus1.bid),   32'(m_id));
                chk32("bid0",   32'(bus0.bid),   32'(m_id));
                chk32("bresp1", 32'(bus1.bresp), (m_err_len || m_err_wid) ? 32'd2 : 32'd0);
                chk32("bresp0", 32'(bus0.bresp), m_err_len ? 32'd2 : 32'd0);
            end else if (rst) begin
                chk32("bid_rst",   32'(bus1.bid),   32'd0);
                chk32("bresp_rst", 32'(bus1.bresp), 32'd0);
            end
        end
    end

    task automatic idle_inputs();
        bus1.awvalid = 1'b0; bus1.awid = '0; bus1.awlen = '0; bus1.awaddr = '0;
        bus1.wvalid = 1'b0; bus1.wid = '0; bus1.wdata = '0; bus1.wlast = 1'b0;
        bus1.bready = 1'b0; bus1.pkt_taken = 1'b0;
    endtask

    // All tasks below start and end at a drive point (1 time unit after posedge).
    task automatic send_aw(input logic [3:0] id, input logic [3:0] len, input logic [31:0] addr);
        bus1.awvalid = 1'b1; bus1.awid = id; bus1.awlen = len; bus1.awaddr = addr;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (bus1.awready) break;
            if (n >= 200) begin timeout("aw_wait"); break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus1.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] id, input logic last, input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        bus1.wvalid = 1'b1; bus1.wdata = data; bus1.wid = id; bus1.wlast = last;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (bus1.wready) break;
            if (n >= 200) begin timeout("w_wait"); break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus1.wvalid = 1'b0; bus1.wlast = 1'b0;
    endtask

    task automatic finish_pkt();
        bus1.pkt_taken = 1'b1;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (bus1.pkt_vld) break;
            if (n >= 200) begin timeout("pkt_wait"); break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus1.pkt_taken = 1'b0;
    endtask

    task automatic get_resp(input logic [3:0] id, input logic [1:0] r1, input logic [1:0] r0);
        @(negedge clk);
        chk1("lit_bvalid", bus1.bvalid, 1'b1);
        chk32("lit_bid", 32'(bus1.bid), 32'(id));
        chk32("lit_bresp1", 32'(bus1.bresp), 32'(r1));
        chk32("lit_bresp0", 32'(bus0.bresp), 32'(r0));
        @(posedge clk); #1;
        bus1.bready = 1'b1;
        @(posedge clk); #1;
        bus1.bready = 1'b0;
    endtask

    initial begin
        logic [551:0] lit;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk1("rst_awready", bus1.awready, 1'b0);
        chkp("rst_pkt", bus1.pkt, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("awready_after_rst", bus1.awready, 1'b1);

        // Single-beat zero-stall round trip
        @(posedge clk); #1;
        bus1.awvalid = 1'b1; bus1.awid = 4'd3; bus1.awlen = 4'd0; bus1.awaddr = 32'h1000;
        @(negedge clk);
        chk1("rt_awready_N", bus1.awready, 1'b1);
        @(posedge clk); #1;
        bus1.awvalid = 1'b0;
        bus1.wvalid = 1'b1; bus1.wdata = 32'hDEADBEEF; bus1.wid = 4'd3; bus1.wlast = 1'b1;
        @(negedge clk);
        chk1("rt_wready_N1", bus1.wready, 1'b1);
        @(posedge clk); #1;
        bus1.wvalid = 1'b0; bus1.wlast = 1'b0;
        bus1.pkt_taken = 1'b1; bus1.bready = 1'b1;
        @(negedge clk);
        lit = '0;
        lit[551:548] = 4'd3;
        lit[543:512] = 32'h1000;
        lit[31:0]    = 32'hDEADBEEF;
        chk1("rt_pkt_vld_N2", bus1.pkt_vld, 1'b1);
        chkp("rt_pkt_N2", bus1.pkt, lit);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("rt_bvalid_N3", bus1.bvalid, 1'b1);
        chk32("rt_bid_N3", 32'(bus1.bid), 32'd3);
        chk32("rt_bresp_N3", 32'(bus1.bresp), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("rt_awready_N4", bus1.awready, 1'b1);
        chk1("rt_bvalid_N4", bus1.bvalid, 1'b0);
        @(posedge clk); #1;
        bus1.pkt_taken = 1'b0; bus1.bready = 1'b0;

        // 16-beat burst with random gaps
        send_aw(4'd1, 4'd15, 32'h2000);
        for (int i = 0; i < 16; i++) begin
            send_w(32'(i), 4'd1, i == 15, int'($urandom_range(0, 3)));
            if (i < 15) begin
                @(negedge clk);
                chk1("len15_no_early_pkt", bus1.pkt_vld, 1'b0);
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        chk1("len15_pkt_vld", bus1.pkt_vld, 1'b1);
        for (int j = 0; j < 16; j++) chk32("len15_word", bus1.pkt[32*j +: 32], 32'(j));
        @(posedge clk); #1;
        finish_pkt();
        get_resp(4'd1, 2'b00, 2'b00);

        // Early wlast: len=3, wlast on beat 1
        send_aw(4'd2, 4'd3, 32'h3000);
        send_w(32'hAAAA0001, 4'd2, 1'b0, 0);
        send_w(32'hBBBB0002, 4'd2, 1'b1, 0);
        @(negedge clk);
        chk1("early_last_pend", bus1.pkt_vld, 1'b1);
        chkp("early_last_words", 552'(bus1.pkt[127:0]), 552'({32'h0, 32'h0, 32'hBBBB0002, 32'hAAAA0001}));
        @(posedge clk); #1;
        finish_pkt();
        get_resp(4'd2, 2'b10, 2'b10);

        // Missing wlast: len=1, no wlast on beat 1
        send_aw(4'd4, 4'd1, 32'h40);
        send_w(32'd11, 4'd4, 1'b0, 0);
        send_w(32'd22, 4'd4, 1'b0, 0);
        @(negedge clk);
        chk1("no_last_pend", bus1.pkt_vld, 1'b1);
        @(posedge clk); #1;
        finish_pkt();
        get_resp(4'd4, 2'b10, 2'b10);

        // wid mismatch: only the checking instance flags it
        send_aw(4'd5, 4'd0, 32'h50);
        send_w(32'h55, 4'd6, 1'b1, 0);
        finish_pkt();
        get_resp(4'd5, 2'b10, 2'b00);

        // Packet held 20 cycles with AW/W pressure
        send_aw(4'd7, 4'd0, 32'h70);
        send_w(32'h77, 4'd7, 1'b1, 0);
        lit = '0;
        lit[551:548] = 4'd7;
        lit[543:512] = 32'h70;
        lit[31:0]    = 32'h77;
        bus1.awvalid = 1'b1; bus1.wvalid = 1'b1; bus1.wdata = 32'hFFFF_FFFF;
        repeat (20) begin
            @(negedge clk);
            chk1("hold_pkt_vld", bus1.pkt_vld, 1'b1);
            chk1("hold_awready", bus1.awready, 1'b0);
            chk1("hold_wready", bus1.wready, 1'b0);
            chkp("hold_pkt", bus1.pkt, lit);
            @(posedge clk); #1;
        end
        bus1.awvalid = 1'b0; bus1.wvalid = 1'b0;
        bus1.pkt_taken = 1'b1;
        @(posedge clk); #1;
        bus1.pkt_taken = 1'b0;
        @(negedge clk);
        chk1("hold_bvalid_next", bus1.bvalid, 1'b1);
        @(posedge clk); #1;
        bus1.bready = 1'b1;
        @(posedge clk); #1;
        bus1.bready = 1'b0;

        // Reset after 2 of 4 beats drops the burst
        send_aw(4'd8, 4'd3, 32'h80);
        send_w(32'd1, 4'd8, 1'b0, 0);
        send_w(32'd2, 4'd8, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk1("mid_rst_awready", bus1.awready, 1'b0);
        chk1("mid_rst_wready", bus1.wready, 1'b0);
        chk1("mid_rst_bvalid", bus1.bvalid, 1'b0);
        chkp("mid_rst_pkt", bus1.pkt, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("mid_rst_release_awready", bus1.awready, 1'b1);
        bus1.bready = 1'b1;
        bus1.pkt_taken = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk1("dropped_no_bvalid", bus1.bvalid, 1'b0);
        end
        @(posedge clk); #1;
        idle_inputs();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            bus1.awvalid   = ($urandom_range(0, 3) == 0);
            bus1.awid      = 4'($urandom);
            bus1.awlen     = 4'($urandom);
            bus1.awaddr    = $urandom;
            bus1.wvalid    = ($urandom_range(0, 2) != 0);
            bus1.wdata     = $urandom;
            bus1.wid       = ($urandom_range(0, 7) == 0) ? 4'($urandom) : m_id;
            bus1.wlast     = ($urandom_range(0, 9) == 0) ||
                             (ph == M_DATA && m_beats == int'(m_len) && $urandom_range(0, 7) != 0);
            bus1.pkt_taken = ($urandom_range(0, 2) == 0);
            bus1.bready    = ($urandom_range(0, 2) == 0);
            rst            = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        idle_inputs();
        repeat (3) begin @(posedge clk); #1; end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
